// File: rtl/game_pkg.sv
// game_pkg: shared game state encoding, XGA timing constants and BCD helper
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_HIT  = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int HBP      = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + HBP;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int VBP      = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + VBP;

    localparam logic [15:0] SCORE_MAX = 16'h9999;

    // Increment a 4-digit BCD value with ripple carry, saturating at 9999
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        if (v == SCORE_MAX) return v;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchroniser, stable-level debounce and rising-edge pulse
module btn_debounce #(
    parameter int DB_CYCLES = 65000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic        sync1_q, sync2_q;
    logic        level_q, level_d, level_prev_q;
    logic [16:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;
    logic        stable, last;

    // Count consecutive samples that differ from the accepted level; accept on the last one
    always_comb begin
        stable  = sync2_q == level_q;
        last    = cnt_q == 17'(DB_CYCLES - 1);
        cnt_d   = (stable || last) ? '0 : cnt_q + 17'd1;
        level_d = (!stable && last) ? sync2_q : level_q;
        pulse_d = level_q & ~level_prev_q;
    end

    // Synchroniser, debounce state and registered edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: game sequencer (start button, lives, BCD survival score, attacker control)
module game_ctrl
    import game_pkg::*;
#(
    parameter int N_ATK        = 4,
    parameter int LIVES_INIT   = 3,
    parameter int HIT_FRAMES   = 60,
    parameter int SCORE_FRAMES = 30,
    parameter int DB_CYCLES    = 65000
) (
    input  logic             clk_65M,
    input  logic             clear_n,
    input  logic             btn_start,
    input  logic [16:0]      H_count,
    input  logic [16:0]      V_count,
    input  logic [N_ATK-1:0] atk_over,
    output logic             game_on,
    output logic             game_stop,
    output logic             clear,
    output logic [2:0]       lives,
    output logic [15:0]      score_bcd,
    output logic [1:0]       state_o
);

    localparam int HW = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;
    localparam int SW = (SCORE_FRAMES > 1) ? $clog2(SCORE_FRAMES) : 1;

    logic          start_p;
    logic          ft_q, hit_any_q, hit_prev_q, hit_rise;
    state_t        state_q, state_d;
    logic [2:0]    lives_q, lives_d;
    logic [15:0]   score_q, score_d;
    logic [SW-1:0] sc_cnt_q, sc_cnt_d;
    logic [HW-1:0] hit_cnt_q, hit_cnt_d;
    logic          game_on_q, game_on_d, game_stop_q, game_stop_d, clear_q, clear_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
        .clk   (clk_65M),
        .rst_n (clear_n),
        .btn   (btn_start),
        .pulse (start_p)
    );

    // Frame tick and attacker hit level, registered before the FSM sees them
    always_ff @(posedge clk_65M or negedge clear_n) begin
        if (!clear_n) begin
            ft_q       <= 1'b0;
            hit_any_q  <= 1'b0;
            hit_prev_q <= 1'b0;
        end else begin
            ft_q       <= (H_count == 17'd0) && (V_count == 17'd0);
            hit_any_q  <= |atk_over;
            hit_prev_q <= hit_any_q;
        end
    end

    assign hit_rise = hit_any_q & ~hit_prev_q;

    // Next-state, lives, score and frame counters; outputs decoded from the next state
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        score_d   = score_q;
        sc_cnt_d  = sc_cnt_q;
        hit_cnt_d = hit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_p) begin
                    state_d  = ST_PLAY;
                    lives_d  = 3'(LIVES_INIT);
                    score_d  = '0;
                    sc_cnt_d = '0;
                end
            end
            ST_PLAY: begin
                if (ft_q) begin
                    sc_cnt_d = (sc_cnt_q == SW'(SCORE_FRAMES - 1)) ? '0 : sc_cnt_q + 1'b1;
                    score_d  = (sc_cnt_q == SW'(SCORE_FRAMES - 1)) ? bcd_inc(score_q) : score_q;
                end
                if (hit_rise) begin
                    hit_cnt_d = '0;
                    state_d   = (lives_q > 3'd1) ? ST_HIT : ST_OVER;
                    lives_d   = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;
                end
            end
            ST_HIT: begin
                if (ft_q) begin
                    hit_cnt_d = (hit_cnt_q == HW'(HIT_FRAMES - 1)) ? '0 : hit_cnt_q + 1'b1;
                    state_d   = (hit_cnt_q == HW'(HIT_FRAMES - 1)) ? ST_PLAY : ST_HIT;
                end
            end
            ST_OVER: begin
                if (start_p) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        game_on_d   = state_d == ST_PLAY;
        game_stop_d = state_d != ST_PLAY;
        clear_d     = (state_d == ST_PLAY) && (state_q != ST_PLAY);
    end

    // FSM state, game registers and registered attacker controls
    always_ff @(posedge clk_65M or negedge clear_n) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            lives_q     <= 3'(LIVES_INIT);
            score_q     <= '0;
            sc_cnt_q    <= '0;
            hit_cnt_q   <= '0;
            game_on_q   <= 1'b0;
            game_stop_q <= 1'b1;
            clear_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            sc_cnt_q    <= sc_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            game_on_q   <= game_on_d;
            game_stop_q <= game_stop_d;
            clear_q     <= clear_d;
        end
    end

    assign game_on   = game_on_q;
    assign game_stop = game_stop_q;
    assign clear     = clear_q;
    assign lives     = lives_q;
    assign score_bcd = score_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: directed scoreboard bench for game_ctrl with short timing parameters
module tb_game_ctrl;

    logic        clk_65M = 1'b0;
    logic        clear_n = 1'b0;
    logic        btn_start = 1'b0;
    logic [16:0] H_count = 17'd1;
    logic [16:0] V_count = 17'd1;
    logic [3:0]  atk_over = 4'b0;
    logic        game_on, game_stop, clear;
    logic [2:0]  lives;
    logic [15:0] score_bcd;
    logic [1:0]  state_o;

    int tests = 0;
    int fails = 0;
    int clear_cnt = 0;
    int play_ticks = 0;

    typedef struct {
        string       tag;
        logic [15:0] v;
    } exp_t;
    exp_t sb[$];

    game_ctrl #(
        .N_ATK(4), .LIVES_INIT(3), .HIT_FRAMES(2), .SCORE_FRAMES(3), .DB_CYCLES(8)
    ) dut (
        .clk_65M(clk_65M), .clear_n(clear_n), .btn_start(btn_start),
        .H_count(H_count), .V_count(V_count), .atk_over(atk_over),
        .game_on(game_on), .game_stop(game_stop), .clear(clear),
        .lives(lives), .score_bcd(score_bcd), .state_o(state_o)
    );

    always #5 clk_65M = ~clk_65M;

    function automatic logic [15:0] bcd_of(input int ticks);
        int n;
        n = ticks / 3;
        if (n > 9999) n = 9999;
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty obs=%h exp=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s obs=%h exp=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic expect_all(input logic [1:0] st, input logic on, input logic stop,
                              input logic [2:0] lv, input logic [15:0] sc);
        push("state", {14'b0, st});
        push("game_on", {15'b0, on});
        push("game_stop", {15'b0, stop});
        push("lives", {13'b0, lv});
        push("score", sc);
    endtask

    task automatic check_all();
        chk({14'b0, state_o});
        chk({15'b0, game_on});
        chk({15'b0, game_stop});
        chk({13'b0, lives});
        chk(score_bcd);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_65M);
            #1;
            if (clear) clear_cnt++;
        end
    endtask

    task automatic frames(input int n, input bit in_play);
        repeat (n) begin
            H_count = 17'd0;
            V_count = 17'd0;
            step(1);
            H_count = 17'd1;
            V_count = 17'd1;
            step(1);
            if (in_play) play_ticks++;
        end
    endtask

    task automatic frames_fast(input int n);
        H_count = 17'd0;
        V_count = 17'd0;
        step(n);
        H_count = 17'd1;
        V_count = 17'd1;
        step(1);
        play_ticks += n;
    endtask

    task automatic press();
        btn_start = 1'b1;
        step(12);
        btn_start = 1'b0;
        step(12);
    endtask

    task automatic hit();
        atk_over = 4'b0101;
        step(2);
        atk_over = 4'b0000;
        step(2);
    endtask

    initial begin
        // reset state
        step(2);
        expect_all(2'b00, 1'b0, 1'b1, 3'd3, 16'h0000);
        check_all();
        push("reset_clear", 16'd0);
        chk({15'b0, clear});
        clear_n = 1'b1;
        step(2);

        // bouncing button never produces a start pulse
        for (int i = 0; i < 10; i++) begin
            btn_start = ~btn_start;
            step(3);
        end
        btn_start = 1'b0;
        step(12);
        push("bounce_state", 16'd0);
        chk({14'b0, state_o});
        push("bounce_clear_cnt", 16'd0);
        chk(16'(clear_cnt));

        // clean press starts the game with one clear pulse
        clear_cnt = 0;
        press();
        push("start_clear_cnt", 16'd1);
        chk(16'(clear_cnt));
        expect_all(2'b01, 1'b1, 1'b0, 3'd3, 16'h0000);
        check_all();
        play_ticks = 0;

        // score counting and BCD carry
        frames(10, 1'b1);
        push("score_10_ticks", 16'h0003);
        chk(score_bcd);
        frames_fast(287);
        push("score_0099", bcd_of(play_ticks));
        chk(score_bcd);
        frames(3, 1'b1);
        push("score_0100", bcd_of(play_ticks));
        chk(score_bcd);

        // double attacker hit counts once, HIT then resume with clear
        hit();
        expect_all(2'b10, 1'b0, 1'b1, 3'd2, bcd_of(play_ticks));
        check_all();
        clear_cnt = 0;
        frames(2, 1'b0);
        step(1);
        push("resume_clear_cnt", 16'd1);
        chk(16'(clear_cnt));
        expect_all(2'b01, 1'b1, 1'b0, 3'd2, bcd_of(play_ticks));
        check_all();
        frames(3, 1'b1);
        push("score_after_hit", bcd_of(play_ticks));
        chk(score_bcd);

        // saturation at 9999
        frames_fast(29997 - play_ticks);
        push("score_9999", 16'h9999);
        chk(score_bcd);
        frames_fast(6);
        push("score_sat", 16'h9999);
        chk(score_bcd);

        // remaining lives lost -> OVER
        hit();
        push("lives_hit2", 16'd1);
        chk({13'b0, lives});
        frames(2, 1'b0);
        step(1);
        hit();
        expect_all(2'b11, 1'b0, 1'b1, 3'd0, 16'h9999);
        check_all();
        press();
        expect_all(2'b00, 1'b0, 1'b1, 3'd0, 16'h9999);
        check_all();
        clear_cnt = 0;
        press();
        push("restart_clear_cnt", 16'd1);
        chk(16'(clear_cnt));
        expect_all(2'b01, 1'b1, 1'b0, 3'd3, 16'h0000);
        check_all();

        // asynchronous reset during HIT
        hit();
        push("pre_reset_state", 16'd2);
        chk({14'b0, state_o});
        clear_n = 1'b0;
        #2;
        expect_all(2'b00, 1'b0, 1'b1, 3'd3, 16'h0000);
        check_all();
        push("async_clear", 16'd0);
        chk({15'b0, clear});
        step(2);
        clear_n = 1'b1;
        step(2);

        if (sb.size() != 0) begin
            tests++;
            fails++;
            $error("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
